// File: rtl/gf16_inv_seq.sv
// Sequential GF(2^4) inverter (poly x^4+x+1): a^-1 = a^14 via square-and-multiply, done 6 edges after start.
// Optional zero_err output is built when GF_INV_ZERO_FLAG_EN is defined.
module gf16_inv_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] a,
  output logic       busy,
  output logic       done,
`ifdef GF_INV_ZERO_FLAG_EN
  output logic [3:0] out_inv,
  output logic       zero_err
`else
  output logic [3:0] out_inv
`endif
);

  localparam int unsigned W  = 4;
  localparam int unsigned PW = 2 * W - 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ1  = 3'd1,
    MUL1 = 3'd2,
    SQ2  = 3'd3,
    MUL2 = 3'd4,
    SQ3  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0] base, acc;
  logic [W-1:0] op_b, prod;
  logic         load, step, fin, use_base;

  // Carry-less 4x4 product folded back with x^4 = x + 1.
  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < int'(W); i++) begin
      if (y[i]) p = p ^ (PW'(x) << i);
    end
    return p[W-1:0]
         ^ ({W{p[4]}} & W'(4'h3))
         ^ ({W{p[5]}} & W'(4'h6))
         ^ ({W{p[6]}} & W'(4'hC));
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SQ1;
      SQ1:     state_nxt = MUL1;
      MUL1:    state_nxt = SQ2;
      SQ2:     state_nxt = MUL2;
      MUL2:    state_nxt = SQ3;
      SQ3:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control decode for the shared multiplier and datapath registers
  always_comb begin
    load     = 1'b0;
    step     = 1'b0;
    fin      = 1'b0;
    use_base = 1'b0;
    case (state)
      IDLE:       load = start;
      SQ1, SQ2:   step = 1'b1;
      MUL1, MUL2: begin
        step     = 1'b1;
        use_base = 1'b1;
      end
      SQ3:        fin = 1'b1;
      default:    ;
    endcase
  end

  assign op_b = use_base ? base : acc;
  assign prod = gf_mul(acc, op_b);

  // Datapath and registered outputs; out_inv only changes on the final square
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base    <= '0;
      acc     <= '0;
      out_inv <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef GF_INV_ZERO_FLAG_EN
      zero_err <= 1'b0;
`endif
    end else begin
      done <= fin;
      if (load) begin
        base <= a;
        acc  <= a;
        busy <= 1'b1;
      end
      if (step) acc <= prod;
      if (fin) begin
        out_inv <= prod;
        busy    <= 1'b0;
`ifdef GF_INV_ZERO_FLAG_EN
        zero_err <= (base == '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_gf16_inv_seq.sv
// Scoreboard bench for gf16_inv_seq: expected inverses come from log/antilog tables of GF(2^4).
module tb_gf16_inv_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic       busy;
  logic       done;
  logic [3:0] out_inv;
`ifdef GF_INV_ZERO_FLAG_EN
  logic       zero_err;
`endif

  gf16_inv_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .busy    (busy),
    .done    (done),
`ifdef GF_INV_ZERO_FLAG_EN
    .out_inv (out_inv),
    .zero_err(zero_err)
`else
    .out_inv (out_inv)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] inv;
    logic       zero;
    int         stamp;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         cyc_left = 0;
  logic [3:0] hold = 4'h0;
  logic       prev_done = 1'b0;
  int         alog[15];
  int         lg[16];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // Reference inverse: a^-1 = g^(15 - log a) with generator g = x
  function automatic logic [3:0] ref_inv(input logic [3:0] v);
    if (v == 4'h0) return 4'h0;
    return 4'(alog[(15 - lg[v]) % 15]);
  endfunction

  initial begin
    int v;
    v = 1;
    for (int i = 0; i < 15; i++) begin
      alog[i] = v;
      lg[v]   = i;
      v = v * 2;
      if (v >= 16) v = v ^ 'h13;
    end
    lg[0] = 0;
  end

  // Acceptance model: a start is taken only when no operation is pending
  always @(posedge clk or posedge rst) begin
    exp_t e;
    if (rst) begin
      cyc_left = 0;
      exp_q.delete();
    end else begin
      cyc = cyc + 1;
      if (cyc_left == 0) begin
        if (start) begin
          e.inv   = ref_inv(a);
          e.zero  = (a == 4'h0);
          e.stamp = cyc;
          exp_q.push_back(e);
          cyc_left = 5;
        end
      end else begin
        cyc_left = cyc_left - 1;
      end
    end
  end

  // Monitor: compare on every done, and check busy / held output every cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst) hold = 4'h0;
    chk("busy", int'(busy), int'(cyc_left != 0));
    if (done) begin
      chk("done_width", int'(prev_done), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_inv", int'(out_inv), int'(e.inv));
        chk("latency", cyc - e.stamp, 5);
`ifdef GF_INV_ZERO_FLAG_EN
        chk("zero_err", int'(zero_err), int'(e.zero));
`endif
        hold = e.inv;
      end
    end
    chk("out_hold", int'(out_inv), int'(hold));
    prev_done = done;
  end

  task automatic run_op(input logic [3:0] val);
    @(negedge clk);
    start = 1'b1;
    a     = val;
    @(negedge clk);
    start = 1'b0;
    a     = 4'($urandom_range(15));
    repeat (7) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = 4'h0;
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out", int'(out_inv), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed operands including zero and back to nonzero
    run_op(4'h2);
    run_op(4'h3);
    run_op(4'h9);
    run_op(4'h1);
    run_op(4'h0);
    run_op(4'h2);

    // start held high with a changing every cycle
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      start = 1'b1;
      a     = 4'($urandom_range(15));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // Asynchronous reset during MUL1
    @(negedge clk);
    start = 1'b1;
    a     = 4'h6;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_out", int'(out_inv), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_out", int'(out_inv), 0);

    // Exhaustive sweep of nonzero operands, then a few random ones
    for (int v = 1; v < 16; v++) run_op(4'(v));
    for (int i = 0; i < 6; i++) run_op(4'($urandom_range(15)));

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
